// File: rtl/key_decoder.sv
// PS/2 set-2 scan-code decoder for four direction keys (arrows or WASD); key/key_event registered, 1-cycle latency.
// Optional macro KEY_DECODER_TIMEOUT_EN discards a stale E0/F0 prefix after TIMEOUT_CYCLES quiet cycles.
module key_decoder #(
    parameter int TIMEOUT_CYCLES = 650000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] key,
    output logic       key_event
);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ext_held_q, ext_held_d;
    logic [3:0] nrm_held_q, nrm_held_d;
    logic [3:0] key_q, key_d;
    logic       key_event_q;
    logic       timeout_hit;

    function automatic logic [3:0] ext_map(input logic [7:0] code);
        case (code)
            8'h6B:   ext_map = 4'b0001;
            8'h74:   ext_map = 4'b0010;
            8'h75:   ext_map = 4'b0100;
            8'h72:   ext_map = 4'b1000;
            default: ext_map = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] nrm_map(input logic [7:0] code);
        case (code)
            8'h1C:   nrm_map = 4'b0001;
            8'h23:   nrm_map = 4'b0010;
            8'h1D:   nrm_map = 4'b0100;
            8'h1B:   nrm_map = 4'b1000;
            default: nrm_map = 4'b0000;
        endcase
    endfunction

`ifdef KEY_DECODER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign timeout_hit = (state_q != IDLE) && !rx_valid && (cnt_q == CNT_MAX);

    // Counts quiet cycles inside a prefix; saturates, and the FSM leaving IDLE-pending clears it.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || rx_valid) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ext_held_d = ext_held_q;
        nrm_held_d = nrm_held_q;
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    // Keyboard housekeeping bytes carry no key information.
                    if (rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
                        state_d = IDLE;
                    end else if (rx_data == 8'hE0) begin
                        state_d = EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_d = BRK;
                    end else begin
                        nrm_held_d = nrm_held_q | nrm_map(rx_data);
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        ext_held_d = ext_held_q | ext_map(rx_data);
                        state_d    = IDLE;
                    end
                end
                BRK: begin
                    nrm_held_d = nrm_held_q & ~nrm_map(rx_data);
                    state_d    = IDLE;
                end
                EXT_BRK: begin
                    ext_held_d = ext_held_q & ~ext_map(rx_data);
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
        key_d = ext_held_d | nrm_held_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ext_held_q  <= 4'b0000;
            nrm_held_q  <= 4'b0000;
            key_q       <= 4'b0000;
            key_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_held_q  <= ext_held_d;
            nrm_held_q  <= nrm_held_d;
            key_q       <= key_d;
            key_event_q <= (key_d != key_q);
        end
    end

    assign key       = key_q;
    assign key_event = key_event_q;

endmodule

// File: tb/tb_key_decoder.sv
// Random and directed scan-code streams checked against a prefix-queue reference model.
module tb_key_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] key;
    logic       key_event;

    always #5 clk = ~clk;

    key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .key       (key),
        .key_event (key_event)
    );

    int vectors = 0;
    int errors  = 0;
    int evt_seen = 0;

    // Reference model: pending prefix bytes, per-map held sets, quiet-cycle count.
    logic [7:0] pend[$];
    logic [3:0] m_ext = 4'b0000;
    logic [3:0] m_nrm = 4'b0000;
    logic       m_evt = 1'b0;
    int         quiet = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int key_index(input logic [7:0] code, input bit extended);
        logic [7:0] ext_codes[4] = '{8'h6B, 8'h74, 8'h75, 8'h72};
        logic [7:0] nrm_codes[4] = '{8'h1C, 8'h23, 8'h1D, 8'h1B};
        for (int i = 0; i < 4; i++) begin
            if (extended ? (ext_codes[i] == code) : (nrm_codes[i] == code)) return i;
        end
        return -1;
    endfunction

    task automatic model(input bit r, input bit v, input logic [7:0] d);
        logic [3:0] prev;
        bit         ext, brk;
        int         idx;
        prev = m_ext | m_nrm;
        if (r) begin
            pend.delete();
            m_ext = 4'b0000;
            m_nrm = 4'b0000;
            quiet = 0;
            m_evt = 1'b0;
            return;
        end
        if (v) begin
            quiet = 0;
            if (pend.size() == 0) begin
                if (d inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
                end else if (d == 8'hE0 || d == 8'hF0) begin
                    pend.push_back(d);
                end else begin
                    idx = key_index(d, 1'b0);
                    if (idx >= 0) m_nrm[idx] = 1'b1;
                end
            end else if (pend.size() == 1 && pend[0] == 8'hE0 && d == 8'hF0) begin
                pend.push_back(d);
            end else begin
                ext = (pend[0] == 8'hE0);
                brk = (pend[pend.size()-1] == 8'hF0);
                idx = key_index(d, ext);
                if (idx >= 0) begin
                    if (ext) m_ext[idx] = !brk;
                    else     m_nrm[idx] = !brk;
                end
                pend.delete();
            end
        end else if (pend.size() != 0) begin
`ifdef KEY_DECODER_TIMEOUT_EN
            quiet++;
            if (quiet >= TO) begin
                pend.delete();
                quiet = 0;
            end
`endif
        end
        m_evt = ((m_ext | m_nrm) != prev);
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input string tag);
        @(negedge clk);
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model(r, v, d);
        #1;
        chk({tag, ".key"}, {4'b0000, key}, {4'b0000, m_ext | m_nrm});
        chk({tag, ".evt"}, {7'd0, key_event}, {7'd0, m_evt});
        evt_seen += int'(key_event);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, tag);
    endtask

    logic [7:0] pool[14] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C,
                             8'h23, 8'h1D, 8'h1B, 8'hAA, 8'hFA, 8'h34, 8'hE0};

    initial begin
        // Reset state
        step(1'b1, 1'b0, 8'h00, "reset");
        chk("reset.key_const", {4'b0000, key}, 8'h00);
        step(1'b0, 1'b0, 8'h00, "reset_rel");

        // Extended make then break of up
        evt_seen = 0;
        step(1'b0, 1'b1, 8'hE0, "up_make");
        step(1'b0, 1'b1, 8'h75, "up_make");
        chk("up_make.key_const", {4'b0000, key}, 8'h04);
        idle(2, "up_make");
        chk("up_make.events", 8'(evt_seen), 8'd1);
        evt_seen = 0;
        step(1'b0, 1'b1, 8'hE0, "up_brk");
        step(1'b0, 1'b1, 8'hF0, "up_brk");
        step(1'b0, 1'b1, 8'h75, "up_brk");
        chk("up_brk.key_const", {4'b0000, key}, 8'h00);
        idle(2, "up_brk");
        chk("up_brk.events", 8'(evt_seen), 8'd1);

        // Typematic W
        evt_seen = 0;
        step(1'b0, 1'b1, 8'h1D, "typem");
        step(1'b0, 1'b1, 8'h1D, "typem");
        step(1'b0, 1'b1, 8'h1D, "typem");
        idle(2, "typem");
        chk("typem.key_const", {4'b0000, key}, 8'h04);
        chk("typem.events", 8'(evt_seen), 8'd1);
        step(1'b0, 1'b1, 8'hF0, "typem_clr");
        step(1'b0, 1'b1, 8'h1D, "typem_clr");

        // Left held via both maps
        step(1'b0, 1'b1, 8'h1C, "dual");
        step(1'b0, 1'b1, 8'hE0, "dual");
        step(1'b0, 1'b1, 8'h6B, "dual");
        step(1'b0, 1'b1, 8'hF0, "dual");
        step(1'b0, 1'b1, 8'h1C, "dual");
        chk("dual.key0_held", {7'd0, key[0]}, 8'd1);
        step(1'b0, 1'b1, 8'hE0, "dual");
        step(1'b0, 1'b1, 8'hF0, "dual");
        step(1'b0, 1'b1, 8'h6B, "dual");
        chk("dual.key0_rel", {7'd0, key[0]}, 8'd0);

        // Ignored and unmapped bytes, then confirm FSM returned to IDLE
        evt_seen = 0;
        step(1'b0, 1'b1, 8'hAA, "ign");
        step(1'b0, 1'b1, 8'hFA, "ign");
        step(1'b0, 1'b1, 8'hE0, "ign");
        step(1'b0, 1'b1, 8'hF0, "ign");
        step(1'b0, 1'b1, 8'h34, "ign");
        chk("ign.events", 8'(evt_seen), 8'd0);
        step(1'b0, 1'b1, 8'h23, "ign_idle");
        chk("ign_idle.key_const", {4'b0000, key}, 8'h02);
        step(1'b0, 1'b1, 8'hF0, "ign_idle");
        step(1'b0, 1'b1, 8'h23, "ign_idle");

        // Reset mid-sequence, coincident with a byte
        step(1'b0, 1'b1, 8'h1B, "rstmid");
        step(1'b0, 1'b1, 8'hE0, "rstmid");
        step(1'b1, 1'b1, 8'h74, "rstmid");
        chk("rstmid.key_const", {4'b0000, key}, 8'h00);
        step(1'b0, 1'b1, 8'h74, "rstmid");
        chk("rstmid.after", {4'b0000, key}, 8'h00);

        // Stale prefix timeout
        step(1'b0, 1'b1, 8'hE0, "tmo");
        idle(20, "tmo");
        step(1'b0, 1'b1, 8'h1D, "tmo");
`ifdef KEY_DECODER_TIMEOUT_EN
        chk("tmo.key_const", {4'b0000, key}, 8'h04);
`else
        chk("tmo.key_const", {4'b0000, key}, 8'h00);
`endif
        step(1'b1, 1'b0, 8'h00, "tmo_rst");

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            bit         r, v;
            logic [7:0] d;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 13)] : 8'($urandom);
            step(r, v, d, "rand");
            if ($urandom_range(0, 49) == 0) idle($urandom_range(10, 20), "rand_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 TIMEOUT_CYCLES, 650000, cycles without an rx byte before a pending prefix is discarded (10 ms at 65 MHz).
REQ-002 clk  input  1  system clock (65 MHz domain), all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 rx_data  input  8  scan-code byte from the PS/2 receiver.
REQ-005 rx_valid  input  1  one-cycle strobe, rx_data valid this cycle.
REQ-006 key  output  4  held-key vector: [0] left, [1] right, [2] up, [3] down; 1 = held.
REQ-007 key_event  output  1  one-cycle pulse when key changes value.

Function
REQ-008 FSM states SHALL be IDLE, BRK, EXT, EXT_BRK; state advances only on cycles with rx_valid=1.
REQ-009 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte -> make of a normal code, stay IDLE.
REQ-010 EXT: 0xF0 -> EXT_BRK; other byte -> make of an extended code -> IDLE.
REQ-011 BRK: any byte -> break of a normal code -> IDLE; EXT_BRK: any byte -> break of an extended code -> IDLE.
REQ-012 Extended map: 0x6B left, 0x74 right, 0x75 up, 0x72 down; normal map: 0x1C (A) left, 0x23 (D) right, 0x1D (W) up, 0x1B (S) down.
REQ-013 Two internal 4-bit held registers SHALL exist, ext_held and nrm_held; make sets, break clears, only the bit of the mapped code.
REQ-014 key SHALL equal ext_held OR nrm_held, registered; key reflects a completing byte on the cycle after its rx_valid (1-cycle latency).
REQ-015 Unmapped codes SHALL complete the sequence (return to IDLE) without altering held registers.
REQ-016 In IDLE, bytes 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF SHALL be ignored (no state change, no register change).
REQ-017 Typematic repeat make of an already-held key SHALL leave key unchanged and SHALL NOT pulse key_event.
REQ-018 key_event SHALL assert for exactly one cycle, coincident with the first cycle key shows the new value.
REQ-019 Break for a code held via the other map (e.g. W held, E0 F0 75) clears only ext bit; key[2] stays 1 while nrm_held[2]=1.
REQ-020 Back-to-back rx_valid on consecutive cycles SHALL each be processed; no byte dropped.

Reset
REQ-021 rst=1 SHALL force state IDLE, ext_held=0, nrm_held=0, key=4'b0000, key_event=0, timeout counter=0 at the next edge.
REQ-022 rst SHALL take priority over a simultaneous rx_valid; that byte is discarded.
REQ-023 rst mid-sequence (e.g. after 0xE0) SHALL drop the prefix; next byte is decoded from IDLE.

Configuration
REQ-024 Macro KEY_DECODER_TIMEOUT_EN: when defined, a counter SHALL count cycles while state != IDLE and clear on rx_valid; reaching TIMEOUT_CYCLES-1 SHALL return FSM to IDLE without changing held registers or key.
REQ-025 Counter width SHALL be $clog2(TIMEOUT_CYCLES) bits, saturating not wrapping; counter held at 0 in IDLE.
REQ-026 When KEY_DECODER_TIMEOUT_EN undefined, no counter SHALL be synthesised; a pending prefix persists indefinitely.

Verification
REQ-027 Reset, then E0 75 -> key=4'b0100 one cycle after second strobe, key_event pulses once; then E0 F0 75 -> key=4'b0000, key_event pulses once.
REQ-028 1D, 1D, 1D (typematic) -> key=4'b0100 after first byte, single key_event only.
REQ-029 1C then E0 6B then F0 1C -> key[0] stays 1 throughout; E0 F0 6B -> key[0]=0.
REQ-030 AA, FA, E0 F0 34 (unmapped) on consecutive cycles -> key stays 0000, no key_event, FSM ends IDLE.
REQ-031 E0 then rst=1 coincident with rx_valid 74 -> key=0000; next 74 alone -> no change (normal-map unmapped).
REQ-032 With KEY_DECODER_TIMEOUT_EN, TIMEOUT_CYCLES=16: E0, wait 20 cycles, 1D -> key=4'b0100 (decoded as normal W); without macro same stimulus -> key unchanged (decoded as extended 1D, unmapped).
